slave_resp_unit: RTL



---
 rtl/bus_resp_pkg.sv | 25 ++
 rtl/slave_mem_array.sv | 26 ++
 rtl/slave_resp_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_resp_pkg.sv
// Shared bus response definitions: response codes, slave FSM states and
// master identifiers. The bus controller decodes the same response codes.
package bus_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_R1   = 3'd3,
        ST_R2   = 3'd4
    } slv_state_e;

    typedef enum logic {
        MID_M1 = 1'b0,
        MID_M2 = 1'b1
    } mid_e;

endpackage

// File: rtl/slave_mem_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset.
module slave_mem_array #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int MAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [MAW-1:0]    waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [MAW-1:0]    raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slave_resp_unit.sv
// Bus slave responder: wait-state insertion, OKAY/ERROR/RETRY/SPLIT responses
// and tracking of a single outstanding split transaction.
module slave_resp_unit
    import bus_resp_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int SPLIT_BASE = 12,
    parameter int WAIT_CYC   = 1,
    parameter int SPLIT_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              master_id,
    output logic              rdyout,
    output logic [1:0]        respout,
    output logic              split,
    output logic              split_mid,
    output logic              split_done,
    output logic [DATA_W-1:0] rdata
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] SPLIT_A   = ADDR_W'(SPLIT_BASE);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYC - 1);
    localparam logic [7:0]        LAT_INIT  = 8'(SPLIT_LAT);

    slv_state_e        state_q, state_d;
    logic [MAW-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    resp_e             code_q, code_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              reissue_q, reissue_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [7:0]        sp_cnt_q, sp_cnt_d;
    logic              sp_pend_q, sp_pend_d;
    logic              sp_ready_q, sp_ready_d;
    logic              sp_mid_q, sp_mid_d;
    logic [ADDR_W-1:0] sp_addr_q, sp_addr_d;
    logic              sp_done_q, sp_done_d;

    logic              rd_load, mem_we, split_start, split_clr;
    logic [MAW-1:0]    rd_addr;
    logic [DATA_W-1:0] mem_rdata;

    // A read issued straight from IDLE (zero wait) must use the live address.
    assign rd_addr = (state_q == ST_IDLE) ? addr[MAW-1:0] : addr_q;

    slave_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .MAW    (MAW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we & ~rst),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // Transfer FSM: accept/decode in IDLE, wait states, two-cycle responses.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        code_d      = code_q;
        wcnt_d      = wcnt_q;
        reissue_d   = reissue_q;
        rd_load     = 1'b0;
        mem_we      = 1'b0;
        split_start = 1'b0;
        split_clr   = 1'b0;
        rdyout      = 1'b1;
        respout     = RESP_OKAY;
        unique case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    addr_d    = addr[MAW-1:0];
                    wdata_d   = wdata;
                    rw_d      = read_write;
                    reissue_d = 1'b0;
                    code_d    = RESP_OKAY;
                    if (addr >= DEPTH_A) begin
                        code_d  = RESP_ERROR;
                        state_d = ST_R1;
                    end else if (sp_pend_q) begin
                        code_d  = RESP_RETRY;
                        state_d = ST_R1;
                    end else if (sp_ready_q && (master_id != sp_mid_q)) begin
                        code_d  = RESP_RETRY;
                        state_d = ST_R1;
                    end else if (sp_ready_q && (addr == sp_addr_q)) begin
                        // Owner re-issues the split transfer: no wait states.
                        reissue_d = 1'b1;
                        state_d   = ST_DONE;
                        rd_load   = ~read_write;
                    end else if (addr >= SPLIT_A) begin
                        code_d      = RESP_SPLIT;
                        state_d     = ST_R1;
                        split_start = 1'b1;
                    end else if (WAIT_CYC == 0) begin
                        state_d = ST_DONE;
                        rd_load = ~read_write;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                rdyout = 1'b0;
                if (wcnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    rd_load = ~rw_q;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                mem_we    = rw_q;
                split_clr = reissue_q;
                state_d   = ST_IDLE;
            end
            ST_R1: begin
                rdyout  = 1'b0;
                respout = code_q;
                state_d = ST_R2;
            end
            ST_R2: begin
                respout = code_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rdata_d = rd_load ? mem_rdata : rdata_q;
    end

    // Split tracker: free-running countdown, then wait for the owner's re-issue.
    always_comb begin
        sp_cnt_d   = sp_cnt_q;
        sp_pend_d  = sp_pend_q;
        sp_ready_d = sp_ready_q;
        sp_mid_d   = sp_mid_q;
        sp_addr_d  = sp_addr_q;
        sp_done_d  = 1'b0;
        if (sp_pend_q) begin
            sp_cnt_d = sp_cnt_q - 8'd1;
            if (sp_cnt_q == 8'd1) begin
                sp_pend_d  = 1'b0;
                sp_ready_d = 1'b1;
                sp_done_d  = 1'b1;
            end
        end
        if (split_clr) begin
            sp_ready_d = 1'b0;
        end
        if (split_start) begin
            sp_cnt_d   = LAT_INIT;
            sp_pend_d  = 1'b1;
            sp_ready_d = 1'b0;
            sp_mid_d   = master_id;
            sp_addr_d  = addr;
        end
    end

    // State registers with synchronous reset; memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            code_q     <= RESP_OKAY;
            wcnt_q     <= '0;
            reissue_q  <= 1'b0;
            rdata_q    <= '0;
            sp_cnt_q   <= '0;
            sp_pend_q  <= 1'b0;
            sp_ready_q <= 1'b0;
            sp_mid_q   <= 1'b0;
            sp_addr_q  <= '0;
            sp_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            code_q     <= code_d;
            wcnt_q     <= wcnt_d;
            reissue_q  <= reissue_d;
            rdata_q    <= rdata_d;
            sp_cnt_q   <= sp_cnt_d;
            sp_pend_q  <= sp_pend_d;
            sp_ready_q <= sp_ready_d;
            sp_mid_q   <= sp_mid_d;
            sp_addr_q  <= sp_addr_d;
            sp_done_q  <= sp_done_d;
        end
    end

    assign split      = sp_pend_q | sp_ready_q;
    assign split_mid  = sp_mid_q;
    assign split_done = sp_done_q;
    assign rdata      = rdata_q;

endmodule
